decode_stage: RTL and testbench
===============================

# decode_stage

Parametrised successor to the current decode unit. It sits between the fetch unit and the execution unit and replaces the stall/bubble pair with a valid/ready handshake. It adds an optional 2-entry skid buffer, generates immediates fully sign-extended to XLEN, and produces one-hot type flags, an ALU opcode, a register-write flag and an illegal-instruction flag. It also gives branch-flush priority over every other event.

## Interface
- XLEN, 32: datapath width (32 or 64); immediates and PC are XLEN bits.
- PC_INIT, 0: xu_pc_o value after reset.
- SKID_EN, 1: 1 = 2-entry skid buffer with registered fu_ready_o; 0 = single register with combinational ready.
- NOP_INSTR, 32'h0000_0013: instruction word held while empty or after flush.
- clock_i  in  1  single clock; all state on rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- fu_valid_i  in  1  fetch presents an instruction.
- fu_ready_o  out  1  decode accepts this cycle.
- fu_instr_i  in  32  instruction word.
- fu_pc_i  in  XLEN  instruction PC.
- fu_pred_taken_i  in  1  fetch predicted taken; travels with the instruction.
- flush_i  in  1  branch mispredict from execute; kills all held entries.
- xu_valid_o  out  1  decoded instruction available.
- xu_ready_i  in  1  execute accepts.
- xu_instr_o  out  32  raw instruction.
- xu_pc_o  out  XLEN  PC.
- xu_pred_taken_o  out  1  carried prediction bit.
- xu_opcode_o  out  7  instr[6:0].
- xu_funct3_o  out  3  instr[14:12].
- xu_funct7_o  out  7  instr[31:25].
- xu_rs1_o  out  5  instr[19:15].
- xu_rs2_o  out  5  instr[24:20].
- xu_rd_o  out  5  instr[11:7].
- xu_type_o  out  6  one-hot {R,I,S,B,U,J}.
- xu_alu_op_o  out  4  ALU operation.
- xu_imm_o  out  XLEN  sign-extended immediate for the decoded type.
- xu_rd_we_o  out  1  writes rd (R/I/U/J type and rd≠0).
- xu_illegal_o  out  1  unsupported opcode or funct7.
- rf_rs1_o, rf_rs2_o  out  5  register-file read addresses (equal xu_rs1_o/xu_rs2_o).
- rf_read_en_o  out  1  equals xu_valid_o.

## Operation
- Accept = fu_valid_i & fu_ready_o. Transfer = xu_valid_o & xu_ready_i.
- Storage: main entry M drives all xu_* outputs. Skid entry S exists only when SKID_EN=1. Each entry holds {instr, pc, pred_taken}.
- State machine (SKID_EN=1), states EMPTY, ONE, TWO:
  - EMPTY: accept → ONE (M ← in).
  - ONE, accept & transfer → ONE (M ← in).
  - ONE, accept & !transfer → TWO (S ← in).
  - ONE, !accept & transfer → EMPTY.
  - TWO: transfer → ONE (M ← S).
  - fu_ready_o = (state ≠ TWO), registered.
- SKID_EN=0: states EMPTY and ONE only. fu_ready_o = !M_valid | xu_ready_i.
- Flush: flush_i forces EMPTY on the next edge, regardless of accept or transfer in the same cycle. Instructions presented during a flush cycle are dropped. M.instr ← NOP_INSTR, M.pc ← PC_INIT.
- Decode is combinational from M:
  - Types: ALU → R. LOAD, JALR, ALUI → I. STORE → S. BRANCH → B. LUI, AUIPC → U. JAL → J. Anything else → 0 with illegal = 1.
  - ALU op:
    - R: {funct3, funct7[5]}.
    - ALUI: {funct3, funct7[5]} for funct3 ∈ {001,101}, otherwise {funct3, 0}.
    - BRANCH: SUB (0001).
    - LOAD, STORE, LUI, AUIPC, JAL, JALR: ADD (0000).
    - Illegal: 1111.
  - R type with funct7 ∉ {0000000, 0100000} → illegal.
  - Immediates (sign bit instr[31] replicated to XLEN):
    - I: instr[31:20].
    - S: {instr[31:25], instr[11:7]}.
    - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
    - U: {instr[31:12], 12'b0}.
    - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - R type → imm = 0.
- Decode outputs are qualified by xu_valid_o. When EMPTY they decode NOP_INSTR (I type, ADD, rd_we = 0, illegal = 0).

## Timing
- Reset values: xu_valid_o = 0, fu_ready_o = 1, xu_instr_o = NOP_INSTR, xu_pc_o = PC_INIT, xu_pred_taken_o = 0, state EMPTY.
- Latency: an instruction accepted at edge N is visible at the outputs after edge N (one cycle).
- Throughput: one instruction per cycle with xu_ready_i held high.
- xu_* outputs are held stable while xu_valid_o = 1 and xu_ready_i = 0.
- In TWO, fu_ready_o falls on the edge that fills S and rises on the edge after the first transfer.
- If reset is asserted mid-operation, all entries are lost immediately (asynchronously).

## Structure
- Add to cpu_core_pkg:
  - alu_op_e with ADD = 0000, SUB = 0001, ILLG = 1111.
  - dec_state_e {EMPTY, ONE, TWO}.
  - Type bit indices TYPE_R..TYPE_J.
  - instr_entry_t struct {instr, pc, pred_taken}.
  - Opcode constants stay in the package.
- Sub-module decode_logic (combinational): instr → type, alu_op, imm, rd_we, illegal. It is instantiated once, on M.

## Test plan
- Reset: assert reset_i, then release → xu_valid_o = 0, fu_ready_o = 1, xu_pc_o = PC_INIT, xu_instr_o = 0x00000013.
- Stream: five back-to-back ADDI with xu_ready_i = 1 → five consecutive xu_valid_o cycles, first one cycle after the first accept, PCs in order.
- Backpressure: xu_ready_i = 0 while three instructions are offered → two held (M, S), fu_ready_o = 0, third held off. Release → order preserved, no loss or duplicate.
- Flush in TWO with fu_valid_i = 1 → next cycle xu_valid_o = 0, both entries and the offered instruction dropped, fu_ready_o = 1.
- Immediates, XLEN=64: BEQ with offset −4 (0xFE000EE3) → imm = 0xFFFF_FFFF_FFFF_FFFC, type B, alu_op SUB. LUI 0x80000 → imm = 0xFFFF_FFFF_8000_0000.
- Illegal: opcode 0x7F or R type with funct7 = 0x01 → xu_illegal_o = 1, alu_op 1111, rd_we = 0. SRAI x1,x2,3 → alu_op 1011.

Source files
------------

// File: rtl/cpu_core_pkg.sv
// Shared decode-stage types: opcodes, ALU op encodings, FSM states and the
// pipeline entry record carried from fetch to execute.
package cpu_core_pkg;

    localparam int XLEN_MAX = 64;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_ALU    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Bit positions inside the one-hot {R,I,S,B,U,J} type vector
    localparam int TYPE_R = 5;
    localparam int TYPE_I = 4;
    localparam int TYPE_S = 3;
    localparam int TYPE_B = 2;
    localparam int TYPE_U = 1;
    localparam int TYPE_J = 0;

    typedef enum logic [3:0] {
        ADD  = 4'b0000,
        SUB  = 4'b0001,
        ILLG = 4'b1111
    } alu_op_e;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } dec_state_e;

    // pc is sized for the widest datapath; narrower builds zero-extend it
    typedef struct packed {
        logic [31:0]         instr;
        logic [XLEN_MAX-1:0] pc;
        logic                pred_taken;
    } instr_entry_t;

endpackage

// File: rtl/decode_logic.sv
// Combinational instruction decoder: type flags, ALU op, sign-extended
// immediate, rd write enable and illegal flag from a raw instruction word.
module decode_logic
    import cpu_core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [5:0]      itype,
    output logic [3:0]      alu_op,
    output logic [XLEN-1:0] imm,
    output logic            rd_we,
    output logic            illegal
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic [31:0] imm32;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        itype   = '0;
        alu_op  = ADD;
        imm32   = '0;
        illegal = 1'b0;
        case (opcode)
            OP_ALU: begin
                if (funct7 == F7_BASE || funct7 == F7_ALT) begin
                    itype[TYPE_R] = 1'b1;
                    alu_op        = {funct3, funct7[5]};
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_ALUI: begin
                itype[TYPE_I] = 1'b1;
                imm32         = imm_i;
                // Only the shifts use instr[30] to pick logical vs arithmetic
                alu_op        = (funct3 == 3'b001 || funct3 == 3'b101) ?
                                {funct3, funct7[5]} : {funct3, 1'b0};
            end
            OP_LOAD, OP_JALR: begin
                itype[TYPE_I] = 1'b1;
                imm32         = imm_i;
            end
            OP_STORE: begin
                itype[TYPE_S] = 1'b1;
                imm32         = imm_s;
            end
            OP_BRANCH: begin
                itype[TYPE_B] = 1'b1;
                imm32         = imm_b;
                alu_op        = SUB;
            end
            OP_LUI, OP_AUIPC: begin
                itype[TYPE_U] = 1'b1;
                imm32         = imm_u;
            end
            OP_JAL: begin
                itype[TYPE_J] = 1'b1;
                imm32         = imm_j;
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) alu_op = ILLG;
    end

    assign imm   = XLEN'($signed(imm32));
    assign rd_we = (itype[TYPE_R] | itype[TYPE_I] | itype[TYPE_U] | itype[TYPE_J])
                   && (instr[11:7] != 5'd0);

endmodule

// File: rtl/decode_stage.sv
// Decode stage between fetch and execute: valid/ready handshake, optional
// 2-entry skid buffer, flush priority, and combinational decode of the head.
module decode_stage
    import cpu_core_pkg::*;
#(
    parameter int          XLEN      = 32,
    parameter logic [XLEN-1:0] PC_INIT = '0,
    parameter bit          SKID_EN   = 1'b1,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clock_i,
    input  logic            reset_i,
    input  logic            fu_valid_i,
    output logic            fu_ready_o,
    input  logic [31:0]     fu_instr_i,
    input  logic [XLEN-1:0] fu_pc_i,
    input  logic            fu_pred_taken_i,
    input  logic            flush_i,
    output logic            xu_valid_o,
    input  logic            xu_ready_i,
    output logic [31:0]     xu_instr_o,
    output logic [XLEN-1:0] xu_pc_o,
    output logic            xu_pred_taken_o,
    output logic [6:0]      xu_opcode_o,
    output logic [2:0]      xu_funct3_o,
    output logic [6:0]      xu_funct7_o,
    output logic [4:0]      xu_rs1_o,
    output logic [4:0]      xu_rs2_o,
    output logic [4:0]      xu_rd_o,
    output logic [5:0]      xu_type_o,
    output logic [3:0]      xu_alu_op_o,
    output logic [XLEN-1:0] xu_imm_o,
    output logic            xu_rd_we_o,
    output logic            xu_illegal_o,
    output logic [4:0]      rf_rs1_o,
    output logic [4:0]      rf_rs2_o,
    output logic            rf_read_en_o
);

    localparam instr_entry_t NOP_ENTRY = '{
        instr:      NOP_INSTR,
        pc:         XLEN_MAX'(PC_INIT),
        pred_taken: 1'b0
    };

    dec_state_e   state;
    instr_entry_t m;
    instr_entry_t s;
    instr_entry_t in_entry;
    logic         ready_q;
    logic         accept;
    logic         transfer;
    logic         dec_rd_we;
    logic         dec_illegal;

    assign in_entry = '{
        instr:      fu_instr_i,
        pc:         XLEN_MAX'(fu_pc_i),
        pred_taken: fu_pred_taken_i
    };

    assign xu_valid_o = (state != EMPTY);
    // Without the skid entry, M can only take a new word if it drains this cycle
    assign fu_ready_o = SKID_EN ? ready_q : (!xu_valid_o || xu_ready_i);
    assign accept     = fu_valid_i && fu_ready_o;
    assign transfer   = xu_valid_o && xu_ready_i;

    // With SKID_EN=0 the ONE/accept/!transfer arc is unreachable, so S is never filled
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state   <= EMPTY;
            m       <= NOP_ENTRY;
            s       <= NOP_ENTRY;
            ready_q <= 1'b1;
        end else if (flush_i) begin
            state   <= EMPTY;
            m       <= NOP_ENTRY;
            s       <= NOP_ENTRY;
            ready_q <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        m     <= in_entry;
                        state <= ONE;
                    end
                end
                ONE: begin
                    if (accept && transfer) begin
                        m <= in_entry;
                    end else if (accept) begin
                        s       <= in_entry;
                        state   <= TWO;
                        ready_q <= 1'b0;
                    end else if (transfer) begin
                        m     <= NOP_ENTRY;
                        state <= EMPTY;
                    end
                end
                TWO: begin
                    if (transfer) begin
                        m       <= s;
                        s       <= NOP_ENTRY;
                        state   <= ONE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state   <= EMPTY;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    generate
        if (XLEN < XLEN_MAX) begin : g_pc_hi
            logic pc_hi_unused;
            assign pc_hi_unused = ^m.pc[XLEN_MAX-1:XLEN];
        end
    endgenerate

    decode_logic #(.XLEN(XLEN)) u_decode (
        .instr   (m.instr),
        .itype   (xu_type_o),
        .alu_op  (xu_alu_op_o),
        .imm     (xu_imm_o),
        .rd_we   (dec_rd_we),
        .illegal (dec_illegal)
    );

    assign xu_instr_o      = m.instr;
    assign xu_pc_o         = m.pc[XLEN-1:0];
    assign xu_pred_taken_o = m.pred_taken;
    assign xu_opcode_o     = m.instr[6:0];
    assign xu_funct3_o     = m.instr[14:12];
    assign xu_funct7_o     = m.instr[31:25];
    assign xu_rs1_o        = m.instr[19:15];
    assign xu_rs2_o        = m.instr[24:20];
    assign xu_rd_o         = m.instr[11:7];
    assign xu_rd_we_o      = dec_rd_we && xu_valid_o;
    assign xu_illegal_o    = dec_illegal && xu_valid_o;
    assign rf_rs1_o        = m.instr[19:15];
    assign rf_rs2_o        = m.instr[24:20];
    assign rf_read_en_o    = xu_valid_o;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage (XLEN=64, skid buffer on): decode vector
// table plus hand-written handshake, backpressure, flush and reset sequences.
module tb_decode_stage;

    localparam int          XLEN    = 64;
    localparam logic [63:0] PC_INIT = 64'h0000_0000_0000_1000;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic            clk;
    logic            rst;
    logic            fu_valid;
    logic            fu_ready;
    logic [31:0]     fu_instr;
    logic [XLEN-1:0] fu_pc;
    logic            fu_pred;
    logic            flush;
    logic            xu_valid;
    logic            xu_ready;
    logic [31:0]     xu_instr;
    logic [XLEN-1:0] xu_pc;
    logic            xu_pred;
    logic [6:0]      xu_opcode;
    logic [2:0]      xu_funct3;
    logic [6:0]      xu_funct7;
    logic [4:0]      xu_rs1;
    logic [4:0]      xu_rs2;
    logic [4:0]      xu_rd;
    logic [5:0]      xu_type;
    logic [3:0]      xu_alu_op;
    logic [XLEN-1:0] xu_imm;
    logic            xu_rd_we;
    logic            xu_illegal;
    logic [4:0]      rf_rs1;
    logic [4:0]      rf_rs2;
    logic            rf_read_en;

    int tests = 0;
    int fails = 0;

    decode_stage #(
        .XLEN(XLEN), .PC_INIT(PC_INIT), .SKID_EN(1'b1), .NOP_INSTR(NOP)
    ) dut (
        .clock_i(clk), .reset_i(rst),
        .fu_valid_i(fu_valid), .fu_ready_o(fu_ready), .fu_instr_i(fu_instr),
        .fu_pc_i(fu_pc), .fu_pred_taken_i(fu_pred), .flush_i(flush),
        .xu_valid_o(xu_valid), .xu_ready_i(xu_ready), .xu_instr_o(xu_instr),
        .xu_pc_o(xu_pc), .xu_pred_taken_o(xu_pred), .xu_opcode_o(xu_opcode),
        .xu_funct3_o(xu_funct3), .xu_funct7_o(xu_funct7), .xu_rs1_o(xu_rs1),
        .xu_rs2_o(xu_rs2), .xu_rd_o(xu_rd), .xu_type_o(xu_type),
        .xu_alu_op_o(xu_alu_op), .xu_imm_o(xu_imm), .xu_rd_we_o(xu_rd_we),
        .xu_illegal_o(xu_illegal), .rf_rs1_o(rf_rs1), .rf_rs2_o(rf_rs2),
        .rf_read_en_o(rf_read_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [5:0]  typ;
        logic [3:0]  alu;
        logic [63:0] imm;
        logic        we;
        logic        ill;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic offer(input logic [31:0] i, input logic [63:0] p, input logic t);
        fu_valid = 1'b1;
        fu_instr = i;
        fu_pc    = p;
        fu_pred  = t;
    endtask

    initial begin
        // {instr, type{R,I,S,B,U,J}, alu_op, imm, rd_we, illegal}
        vecs[0]  = '{32'hFFF10093, 6'b010000, 4'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0}; // addi x1,x2,-1
        vecs[1]  = '{32'hFE000EE3, 6'b000100, 4'h1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0}; // beq -4
        vecs[2]  = '{32'h800002B7, 6'b000010, 4'h0, 64'hFFFF_FFFF_8000_0000, 1'b1, 1'b0}; // lui x5,0x80000
        vecs[3]  = '{32'h40315093, 6'b010000, 4'hB, 64'h0000_0000_0000_0403, 1'b1, 1'b0}; // srai x1,x2,3
        vecs[4]  = '{32'h0000007F, 6'b000000, 4'hF, 64'h0,                   1'b0, 1'b1}; // bad opcode
        vecs[5]  = '{32'h022081B3, 6'b000000, 4'hF, 64'h0,                   1'b0, 1'b1}; // funct7=0x01
        vecs[6]  = '{32'h402081B3, 6'b100000, 4'h1, 64'h0,                   1'b1, 1'b0}; // sub x3,x1,x2
        vecs[7]  = '{32'hFE20AC23, 6'b001000, 4'h0, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 1'b0}; // sw x2,-8(x1)
        vecs[8]  = '{32'hFFFFF0EF, 6'b000001, 4'h0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0}; // jal x1,-2
        vecs[9]  = '{32'h00000013, 6'b010000, 4'h0, 64'h0,                   1'b0, 1'b0}; // nop, rd=0
        vecs[10] = '{32'h12345117, 6'b000010, 4'h0, 64'h0000_0000_1234_5000, 1'b1, 1'b0}; // auipc x2
        vecs[11] = '{32'h00109093, 6'b010000, 4'h2, 64'h1,                   1'b1, 1'b0}; // slli x1,x1,1
        vecs[12] = '{32'hFFF12093, 6'b010000, 4'h4, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0}; // slti, bit30 ignored
        vecs[13] = '{32'h0080A203, 6'b010000, 4'h0, 64'h8,                   1'b1, 1'b0}; // lw x4,8(x1)
        vecs[14] = '{32'h00008067, 6'b010000, 4'h0, 64'h0,                   1'b0, 1'b0}; // jalr x0,0(x1)
        vecs[15] = '{32'h00208133, 6'b100000, 4'h0, 64'h0,                   1'b1, 1'b0}; // add x2,x1,x2

        rst = 1'b1; fu_valid = 1'b0; fu_instr = '0; fu_pc = '0; fu_pred = 1'b0;
        flush = 1'b0; xu_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset valid", 64'(xu_valid), 64'd0);
        chk("reset fu_ready", 64'(fu_ready), 64'd1);
        chk("reset pc", xu_pc, PC_INIT);
        chk("reset instr", 64'(xu_instr), 64'h13);
        chk("reset pred", 64'(xu_pred), 64'd0);
        chk("reset type", 64'(xu_type), 64'b010000);
        chk("reset rd_we", 64'(xu_rd_we), 64'd0);
        chk("reset illegal", 64'(xu_illegal), 64'd0);
        chk("reset rf_read_en", 64'(rf_read_en), 64'd0);

        // Decode table, streamed back-to-back
        xu_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            logic [31:0] w;
            logic [63:0] p;
            w = vecs[i].instr;
            p = 64'h2000 + 64'(i * 4);
            offer(w, p, i[0]);
            @(negedge clk);
            chk($sformatf("vec%0d valid", i), 64'(xu_valid), 64'd1);
            chk($sformatf("vec%0d instr", i), 64'(xu_instr), 64'(w));
            chk($sformatf("vec%0d pc", i), xu_pc, p);
            chk($sformatf("vec%0d pred", i), 64'(xu_pred), 64'(i[0]));
            chk($sformatf("vec%0d type", i), 64'(xu_type), 64'(vecs[i].typ));
            chk($sformatf("vec%0d alu_op", i), 64'(xu_alu_op), 64'(vecs[i].alu));
            chk($sformatf("vec%0d imm", i), xu_imm, vecs[i].imm);
            chk($sformatf("vec%0d rd_we", i), 64'(xu_rd_we), 64'(vecs[i].we));
            chk($sformatf("vec%0d illegal", i), 64'(xu_illegal), 64'(vecs[i].ill));
            chk($sformatf("vec%0d rs1", i), 64'(rf_rs1), 64'(w[19:15]));
            chk($sformatf("vec%0d rs2", i), 64'(xu_rs2), 64'(w[24:20]));
            chk($sformatf("vec%0d rd", i), 64'(xu_rd), 64'(w[11:7]));
            chk($sformatf("vec%0d fu_ready", i), 64'(fu_ready), 64'd1);
        end
        fu_valid = 1'b0;
        @(negedge clk);
        chk("table drain valid", 64'(xu_valid), 64'd0);
        chk("table drain instr", 64'(xu_instr), 64'h13);

        // Stream: five ADDIs, one valid per cycle, in PC order
        for (int k = 0; k < 5; k++) begin
            offer(32'h0000_0093 | (32'(k) << 20), 64'h100 + 64'(k * 4), 1'b0);
            @(negedge clk);
            chk($sformatf("stream%0d valid", k), 64'(xu_valid), 64'd1);
            chk($sformatf("stream%0d pc", k), xu_pc, 64'h100 + 64'(k * 4));
            chk($sformatf("stream%0d imm", k), xu_imm, 64'(k));
        end
        fu_valid = 1'b0;
        @(negedge clk);
        chk("stream end valid", 64'(xu_valid), 64'd0);

        // Backpressure: A into M, B into S, C held off
        xu_ready = 1'b0;
        offer(32'h00100093, 64'h300, 1'b0);
        @(negedge clk);
        chk("bp A valid", 64'(xu_valid), 64'd1);
        chk("bp A pc", xu_pc, 64'h300);
        chk("bp one fu_ready", 64'(fu_ready), 64'd1);
        offer(32'h00200093, 64'h304, 1'b1);
        @(negedge clk);
        chk("bp two fu_ready", 64'(fu_ready), 64'd0);
        chk("bp two pc", xu_pc, 64'h300);
        offer(32'h00300093, 64'h308, 1'b0);
        @(negedge clk);
        chk("bp held fu_ready", 64'(fu_ready), 64'd0);
        chk("bp held pc", xu_pc, 64'h300);
        chk("bp held instr", 64'(xu_instr), 64'h00100093);
        xu_ready = 1'b1;
        @(negedge clk);
        chk("bp B pc", xu_pc, 64'h304);
        chk("bp B pred", 64'(xu_pred), 64'd1);
        chk("bp B fu_ready", 64'(fu_ready), 64'd1);
        @(negedge clk);
        chk("bp C pc", xu_pc, 64'h308);
        chk("bp C instr", 64'(xu_instr), 64'h00300093);
        fu_valid = 1'b0;
        @(negedge clk);
        chk("bp drained valid", 64'(xu_valid), 64'd0);

        // Flush in TWO with an instruction offered
        xu_ready = 1'b0;
        offer(32'h00400093, 64'h400, 1'b0);
        @(negedge clk);
        offer(32'h00500093, 64'h404, 1'b0);
        @(negedge clk);
        chk("flush2 pre fu_ready", 64'(fu_ready), 64'd0);
        offer(32'h00600093, 64'h408, 1'b1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; fu_valid = 1'b0;
        chk("flush2 valid", 64'(xu_valid), 64'd0);
        chk("flush2 fu_ready", 64'(fu_ready), 64'd1);
        chk("flush2 instr", 64'(xu_instr), 64'h13);
        chk("flush2 pc", xu_pc, PC_INIT);
        xu_ready = 1'b1;
        @(negedge clk);
        chk("flush2 no leak", 64'(xu_valid), 64'd0);

        // Flush in ONE while fetch is accepted: offered word dropped
        xu_ready = 1'b0;
        offer(32'h00700093, 64'h500, 1'b0);
        @(negedge clk);
        offer(32'h00800093, 64'h504, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; fu_valid = 1'b0;
        chk("flush1 valid", 64'(xu_valid), 64'd0);
        chk("flush1 instr", 64'(xu_instr), 64'h13);
        @(negedge clk);
        chk("flush1 no leak", 64'(xu_valid), 64'd0);

        // Asynchronous reset between clock edges
        offer(32'h00900093, 64'h600, 1'b1);
        @(negedge clk);
        fu_valid = 1'b0;
        chk("areset pre valid", 64'(xu_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("areset valid", 64'(xu_valid), 64'd0);
        chk("areset pc", xu_pc, PC_INIT);
        chk("areset pred", 64'(xu_pred), 64'd0);
        chk("areset fu_ready", 64'(fu_ready), 64'd1);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("areset after valid", 64'(xu_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
